// File: rtl/xcore_exe_div_seq.sv
// Sequential 32-bit integer divider that borrows an external adder/comparator ALU.
//   Latency: done pulses in the cycle after the 34th edge following the accept edge
//   (2nd edge for a zero divisor). Backpressure: none; start is accepted only in IDLE,
//   and flush aborts silently.
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   start_i, flush_i               request (IDLE only) / synchronous abort
//   op_signed_i, op_rem_i          signed divide / return remainder instead of quotient
//   dividend_i, divisor_i          operands, captured on the accept edge
//   busy_o, done_o                 not-IDLE flag / one-cycle completion pulse
//   result_o, div_by_zero_o        registered answer, held until the next done
//   alu_*_o, alu_out_i, alu_less_i shared-ALU control, operands and result/compare
module xcore_exe_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic             op_signed_i,
  input  logic             op_rem_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             div_by_zero_o,
  output logic [2:0]       alu_ctrl_o,
  output logic             alu_sub_add_o,
  output logic             alu_u_s_o,
  output logic             alu_a_l_o,
  output logic             alu_l_r_o,
  output logic [WIDTH-1:0] alu_data_a_o,
  output logic [WIDTH-1:0] alu_data_b_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_less_i
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  // Holds the raw dividend until PREP, then its magnitude; during ITER the
  // dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             signed_q;
  logic             op_rem_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             dbz_q;

  logic             dvd_neg_d;
  logic             dvs_neg_d;
  logic [WIDTH-1:0] dvd_mag_d;
  logic [WIDTH-1:0] dvs_mag_d;
  logic [WIDTH-1:0] shifted_d;
  logic             qbit_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] fix_val_d;
  logic             fix_neg_d;

  always_comb begin
    dvd_neg_d = signed_q & dvd_q[WIDTH-1];
    dvs_neg_d = signed_q & dvs_q[WIDTH-1];
    dvd_mag_d = dvd_neg_d ? ({WIDTH{1'b0}} - dvd_q) : dvd_q;
    dvs_mag_d = dvs_neg_d ? ({WIDTH{1'b0}} - dvs_q) : dvs_q;

    shifted_d = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    // A set rem MSB means the shifted partial remainder overflowed WIDTH bits,
    // so it is certainly >= divisor even though the compare says otherwise.
    qbit_d    = rem_q[WIDTH-1] | ~alu_less_i;
    rem_d     = qbit_d ? alu_out_i : shifted_d;

    fix_val_d = op_rem_q ? rem_q : dvd_q;
    fix_neg_d = op_rem_q ? rneg_q : qneg_q;
  end

  // ALU operands depend only on registered state, so they are glitch-free and
  // collapse to zero in IDLE, PREP, DONE and under reset.
  always_comb begin
    alu_ctrl_o    = 3'b000;
    alu_a_l_o     = 1'b0;
    alu_l_r_o     = 1'b0;
    alu_sub_add_o = 1'b0;
    alu_u_s_o     = 1'b0;
    alu_data_a_o  = '0;
    alu_data_b_o  = '0;
    case (state_q)
      S_ITER: begin
        alu_data_a_o  = shifted_d;
        alu_data_b_o  = dvs_q;
        alu_sub_add_o = 1'b1;
        alu_u_s_o     = 1'b1;
      end
      S_FIX: begin
        // 0 - x applies the sign, 0 + x passes the magnitude through.
        alu_data_a_o  = '0;
        alu_data_b_o  = fix_val_d;
        alu_sub_add_o = fix_neg_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      signed_q <= 1'b0;
      op_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            dvd_q    <= dividend_i;
            dvs_q    <= divisor_i;
            signed_q <= op_signed_i;
            op_rem_q <= op_rem_i;
            busy_q   <= 1'b1;
            state_q  <= S_PREP;
          end
        end
        S_PREP: begin
          if (dvs_q == '0) begin
            result_q <= op_rem_q ? dvd_q : {WIDTH{1'b1}};
            dbz_q    <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            dvd_q   <= dvd_mag_d;
            dvs_q   <= dvs_mag_d;
            qneg_q  <= dvd_neg_d ^ dvs_neg_d;
            rneg_q  <= dvd_neg_d;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[WIDTH-2:0], qbit_d};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= alu_out_i;
          dbz_q    <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          // The zero-divisor path arrives with done still low and spends one
          // extra DONE cycle raising it, so it answers two edges after start.
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign result_o      = result_q;
  assign div_by_zero_o = dbz_q;

endmodule
